// File: rtl/icache_refill_if.sv
// Interfaces around the icache line-fill engine.
//
// icache_req_if : miss request from the instruction cache and the line returned
//                 to it. The cache is the master, the refill engine the slave.
//   cache_req_i   level line-fill request
//   cache_addr_i  miss byte address (may be unaligned)
//   cache_valid_o one-cycle pulse: cache_line_o holds the completed line
//   cache_line_o  assembled line, word k at [k*WORD_WIDTH +: WORD_WIDTH]
//
// mem_bus_if    : word-wide pipelined request/grant/rvalid read bus. The refill
//                 engine is the master, the memory the slave.
//   bus_req_o     beat address request
//   bus_addr_o    beat byte address
//   bus_gnt_i     address accepted when bus_req_o && bus_gnt_i
//   bus_rvalid_i  read data valid, returned in grant order
//   bus_rdata_i   read data
//
// The _i/_o suffixes name direction as seen from the refill engine.

interface icache_req_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) ();
    logic                  cache_req_i;
    logic [ADDR_WIDTH-1:0] cache_addr_i;
    logic                  cache_valid_o;
    logic [LINE_WIDTH-1:0] cache_line_o;

    modport master (
        output cache_req_i, cache_addr_i,
        input  cache_valid_o, cache_line_o
    );

    modport slave (
        input  cache_req_i, cache_addr_i,
        output cache_valid_o, cache_line_o
    );
endinterface

interface mem_bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 32
) ();
    logic                  bus_req_o;
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic                  bus_gnt_i;
    logic                  bus_rvalid_i;
    logic [WORD_WIDTH-1:0] bus_rdata_i;

    modport master (
        output bus_req_o, bus_addr_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_addr_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/icache_refill.sv
// icache_refill: line-fill engine behind the instruction cache memory port.
//
// Takes a line miss, fetches the line as BEATS word reads over a pipelined
// request/grant/rvalid bus, assembles the words and returns the line to the
// cache with a single-cycle valid pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   cache  icache_req_if.slave : miss request in, completed line out
//   bus    mem_bus_if.master   : beat requests out, grants/read data in
//   busy_o high whenever the engine is not IDLE
//   err_o  sticky protocol error (read data with no outstanding grant)

module icache_refill #(
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    icache_req_if.slave      cache,
    mem_bus_if.master        bus,
    output logic             busy_o,
    output logic             err_o
);

    localparam int BEATS    = LINE_WIDTH / WORD_WIDTH;
    localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
    localparam int WSTEP    = WORD_WIDTH / 8;
    // One extra bit so the counters can hold the value BEATS itself.
    localparam int CW       = $clog2(BEATS) + 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        (ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_e;

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] base_q,   base_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         recv_q,   recv_d;
    logic [LINE_WIDTH-1:0] line_q,   line_d;
    logic                  err_q,    err_d;

    logic                  bus_req;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  gnt_fire;
    logic                  beat_ok;

    // Next beat address; wraps modulo 2^ADDR_WIDTH, and since base is
    // line-aligned the beats never leave their own line.
    assign bus_req   = (state_q == FILL) && (issued_q < CW'(BEATS));
    assign beat_addr = base_q + ADDR_WIDTH'(issued_q) * ADDR_WIDTH'(WSTEP);
    assign gnt_fire  = bus_req && bus.bus_gnt_i;
    // Read data is only legal in FILL and only for a beat already granted.
    assign beat_ok   = (state_q == FILL) && bus.bus_rvalid_i && (recv_q < issued_q);

    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d  = state_q;
        base_d   = base_q;
        issued_d = issued_q;
        recv_d   = recv_q;
        line_d   = line_q;
        err_d    = err_q;

        // Dropped beat: flag it, the fill in progress carries on.
        if (bus.bus_rvalid_i && !beat_ok) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (cache.cache_req_i) begin
                    base_d   = cache.cache_addr_i & ~OFF_MASK;
                    issued_d = '0;
                    recv_d   = '0;
                    state_d  = FILL;
                end
            end

            FILL: begin
                // Grant and read data in the same cycle are independent.
                if (gnt_fire) begin
                    issued_d = issued_q + CW'(1);
                end
                if (beat_ok) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (recv_q == CW'(k)) begin
                            line_d[k*WORD_WIDTH +: WORD_WIDTH] = bus.bus_rdata_i;
                        end
                    end
                    recv_d = recv_q + CW'(1);
                    if (recv_q == CW'(BEATS - 1)) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // Always pass through IDLE so fills never overlap.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            issued_q <= '0;
            recv_q   <= '0;
            // NOTE: the line register is reset as well, because the cache
            // side must see an all-zero line out of reset, not just no valid.
            line_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only here, so every flop samples
            // the pre-edge value of every other flop.
            state_q  <= state_d;
            base_q   <= base_d;
            issued_q <= issued_d;
            recv_q   <= recv_d;
            line_q   <= line_d;
            err_q    <= err_d;
        end
    end

    assign cache.cache_valid_o = (state_q == DONE);
    assign cache.cache_line_o  = line_q;
    assign bus.bus_req_o       = bus_req;
    assign bus.bus_addr_o      = bus_req ? beat_addr : '0;
    assign busy_o              = (state_q != IDLE);
    assign err_o               = err_q;

endmodule

// File: tb/tb_icache_refill.sv
// Testbench for icache_refill.
// A memory model answers the bus (read data = beat address) with per-beat
// programmable grant and read-data wait cycles. Stimulus pushes the expected
// beat addresses, lines and valid cycles into queues; the memory model and a
// separate line monitor pop and compare when the DUT presents them.

module tb_icache_refill;

    localparam int LW = 128;
    localparam int WW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    always #5 clk = ~clk;

    icache_req_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) cif ();
    mem_bus_if    #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bif ();

    icache_refill #(
        .LINE_WIDTH(LW),
        .WORD_WIDTH(WW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cache  (cif),
        .bus    (bif),
        .busy_o (busy),
        .err_o  (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard queues
    logic [127:0] exp_line_q[$];
    int           exp_cyc_q[$];
    logic [31:0]  exp_addr_q[$];

    // Memory model state
    int          gnt_wait[4];
    int          rv_wait[4];
    int          beat_idx = 0;
    int          wcnt     = 0;
    int          rv_seen  = 0;
    bit          spur_req = 1'b0;
    logic [31:0] raddr_q[$];
    int          dly_q[$];
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr;

    // Bus responses change on the falling edge, away from the DUT's edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bif.bus_gnt_i    = 1'b0;
            bif.bus_rvalid_i = 1'b0;
            bif.bus_rdata_i  = '0;
            raddr_q.delete();
            dly_q.delete();
            beat_idx  = 0;
            wcnt      = 0;
            prev_wait = 1'b0;
        end else begin
            // Data phase: handled before this cycle's grant, so read data
            // trails its grant by at least one cycle.
            bif.bus_rvalid_i = 1'b0;
            bif.bus_rdata_i  = '0;
            if (spur_req) begin
                bif.bus_rvalid_i = 1'b1;
                bif.bus_rdata_i  = 32'hDEAD_BEEF;
                spur_req = 1'b0;
            end else if (raddr_q.size() > 0) begin
                if (dly_q[0] == 0) begin
                    bif.bus_rvalid_i = 1'b1;
                    bif.bus_rdata_i  = raddr_q.pop_front();
                    void'(dly_q.pop_front());
                    rv_seen++;
                end else begin
                    dly_q[0] = dly_q[0] - 1;
                end
            end

            // Address phase
            bif.bus_gnt_i = 1'b0;
            if (bif.bus_req_o) begin
                if (prev_wait) check("addr_stable", bif.bus_addr_o, prev_addr);
                if (wcnt < gnt_wait[beat_idx]) begin
                    wcnt++;
                    prev_wait = 1'b1;
                    prev_addr = bif.bus_addr_o;
                end else begin
                    bif.bus_gnt_i = 1'b1;
                    wcnt = 0;
                    prev_wait = 1'b0;
                    if (exp_addr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL beat_addr: got 0x%0h, expected no request", bif.bus_addr_o);
                    end else begin
                        check("beat_addr", bif.bus_addr_o, exp_addr_q.pop_front());
                    end
                    raddr_q.push_back(bif.bus_addr_o);
                    dly_q.push_back(rv_wait[beat_idx]);
                    beat_idx = (beat_idx + 1) % 4;
                end
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    // Line monitor
    always @(negedge clk) begin
        if (rst_n && cif.cache_valid_o) begin
            if (exp_line_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: line 0x%0h, no fill expected", cif.cache_line_o);
            end else begin
                check("line", cif.cache_line_o, exp_line_q.pop_front());
                check("valid_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
                check("busy_at_valid", 128'(busy), 128'd1);
            end
        end
    end

    task automatic set_waits(input int g1, input int g2, input int r1, input int r2);
        // g1/g2: grant waits on beats 1/2; r1/r2: read-data waits on beats 1/2
        gnt_wait = '{0, g1, g2, 0};
        rv_wait  = '{0, r1, r2, 0};
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        if (busy) check("wait_idle_timeout", 128'(busy), 128'd0);
    endtask

    // Called on a falling edge. Raises the request for one cycle and queues
    // the expected beats, line and valid cycle (lat cycles after acceptance).
    task automatic start_fill(input logic [31:0] addr, input logic [31:0] base,
                              input logic [127:0] line, input int lat);
        wait_idle();
        cif.cache_req_i  = 1'b1;
        cif.cache_addr_i = addr;
        exp_line_q.push_back(line);
        exp_cyc_q.push_back(cyc + lat);
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(base + 32'(4 * k));
        @(negedge clk);
        cif.cache_req_i = 1'b0;
    endtask

    task automatic wait_drained();
        for (int i = 0; i < 200 && exp_line_q.size() > 0; i++) @(negedge clk);
        if (exp_line_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL fill_timeout: %0d lines still pending", exp_line_q.size());
            exp_line_q.delete();
            exp_cyc_q.delete();
            exp_addr_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.cache_req_i  = 1'b0;
        cif.cache_addr_i = '0;
        set_waits(0, 0, 0, 0);
        #1;
        check("rst_valid", 128'(cif.cache_valid_o), 128'd0);
        check("rst_line",  cif.cache_line_o,        128'd0);
        check("rst_req",   128'(bif.bus_req_o),     128'd0);
        check("rst_addr",  128'(bif.bus_addr_o),    128'd0);
        check("rst_busy",  128'(busy),              128'd0);
        check("rst_err",   128'(err),               128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: aligned zero-wait fill, valid 6 cycles after acceptance
        start_fill(32'h0000_0040, 32'h0000_0040,
                   128'h0000004C_00000048_00000044_00000040, 6);
        for (int i = 0; i < 20 && !cif.cache_valid_o; i++) @(negedge clk);
        @(negedge clk);
        check("busy_after_valid", 128'(busy), 128'd0);
        wait_drained();

        // 2: unaligned, gnt withheld 3 cycles on beat 1, rvalid 2 late on beat 2
        set_waits(3, 0, 0, 2);
        start_fill(32'h0000_024C, 32'h0000_0240,
                   128'h0000024C_00000248_00000244_00000240, 11);
        wait_drained();
        check("err_after_waits", 128'(err), 128'd0);
        set_waits(0, 0, 0, 0);

        // 3: spurious read data in IDLE sets the sticky error
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        check("err_spurious", 128'(err), 128'd1);
        check("busy_spurious", 128'(busy), 128'd0);
        start_fill(32'h0000_0080, 32'h0000_0080,
                   128'h0000008C_00000088_00000084_00000080, 6);
        wait_drained();
        check("err_sticky", 128'(err), 128'd1);

        // 4: reset after two beats of a fill abandons it
        rv_seen = 0;
        start_fill(32'h0000_0100, 32'h0000_0100, 128'h0, 6);
        for (int i = 0; i < 20 && rv_seen < 2; i++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_line_q.delete();
        exp_cyc_q.delete();
        exp_addr_q.delete();
        #1;
        check("midrst_valid", 128'(cif.cache_valid_o), 128'd0);
        check("midrst_line",  cif.cache_line_o,        128'd0);
        check("midrst_req",   128'(bif.bus_req_o),     128'd0);
        check("midrst_addr",  128'(bif.bus_addr_o),    128'd0);
        check("midrst_busy",  128'(busy),              128'd0);
        check("midrst_err",   128'(err),               128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_fill(32'h0000_0300, 32'h0000_0300,
                   128'h0000030C_00000308_00000304_00000300, 6);
        wait_drained();

        // 5: back-to-back, request held high through DONE; the second fill
        // is accepted in the IDLE cycle right after the pulse.
        wait_idle();
        cif.cache_req_i  = 1'b1;
        cif.cache_addr_i = 32'h0000_0400;
        exp_line_q.push_back(128'h0000040C_00000408_00000404_00000400);
        exp_cyc_q.push_back(cyc + 6);
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(32'h0000_0400 + 32'(4 * k));
        for (int i = 0; i < 20 && !cif.cache_valid_o; i++) @(negedge clk);
        cif.cache_addr_i = 32'h0000_0504;
        exp_line_q.push_back(128'h0000050C_00000508_00000504_00000500);
        exp_cyc_q.push_back(cyc + 7);
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(32'h0000_0500 + 32'(4 * k));
        @(negedge clk);
        check("b2b_idle_gap", 128'(busy), 128'd0);
        @(negedge clk);
        cif.cache_req_i = 1'b0;
        wait_drained();

        // 6: grant wait on beat 2 and read-data wait on beat 1. Timeline after
        // acceptance: c1 g0; c2 g1,r0; c3 wait; c4 g2,r1; c5 g3+r2 together;
        // c6 r3; c7 valid.
        set_waits(0, 1, 1, 0);
        start_fill(32'h0000_0600, 32'h0000_0600,
                   128'h0000060C_00000608_00000604_00000600, 7);
        wait_drained();
        check("err_simultaneous", 128'(err), 128'd0);
        check("addr_q_empty", 128'(exp_addr_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
